// File: rtl/pool_pkg.sv
// pool_pkg
// Shared types and helpers for the streaming 2-D pooling stage.
//   pool_mode_e  : pooling operation (max / average)
//   pool_state_e : frame-level control states
//   acc_width()  : accumulator width needed to hold a full POOL_SIZE x POOL_SIZE sum
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_e;

    // A window sums POOL_SIZE^2 samples, so the sum grows by 2*log2(POOL_SIZE) bits.
    function automatic int acc_width(input int data_width, input int pool_size);
        return data_width + 2 * $clog2(pool_size);
    endfunction

endpackage

// File: rtl/pool_row_accum.sv
// pool_row_accum
// One-row window accumulator: OUT_WIDTH entries, one per output column.
// Each accepted sample either loads its entry (first sample of a window) or
// combines into it (signed max, or sign-extended add in average mode).
// 'result' is the combine result for the current sample, already reduced to
// the output value; the parent latches it when the sample completes a window.
//
// Optional feature macro: POOL2D_AVG_EN (average mode datapath; without it
// the entries are DATA_WIDTH wide and only max pooling is built).
//
// Ports:
//   clk     : clock
//   fire    : a sample is being accepted this cycle
//   first   : the sample is the first one of its window (load, no combine)
//   mode    : latched pooling mode
//   wc      : output column / accumulator entry index
//   sample  : signed input sample
//   result  : pooled value for the window if this sample completes it
module pool_row_accum
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int POOL_SIZE  = 2,
    parameter int OUT_WIDTH  = 128,
    parameter int WC_W       = 7
) (
    input  logic                  clk,
    input  logic                  fire,
    input  logic                  first,
    input  pool_mode_e            mode,
    input  logic [WC_W-1:0]       wc,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] result
);

`ifdef POOL2D_AVG_EN
    localparam int AW    = acc_width(DATA_WIDTH, POOL_SIZE);
    localparam int SHIFT = 2 * $clog2(POOL_SIZE);
`else
    localparam int AW    = DATA_WIDTH;
    logic unused_mode;
    assign unused_mode = ^mode;
`endif

    // Read-modify-write must complete in the cycle the sample arrives, so the
    // entry is read asynchronously (small distributed RAM, OUT_WIDTH deep).
    logic signed [AW-1:0] acc_mem [OUT_WIDTH];
    logic signed [AW-1:0] entry;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] combined;

    assign entry      = acc_mem[wc];
    assign sample_ext = AW'($signed(sample));

    always_comb begin
        combined = entry;
        if (first) begin
            combined = sample_ext;
`ifdef POOL2D_AVG_EN
        end else if (mode == POOL_AVG) begin
            combined = entry + sample_ext;
`endif
        end else if (sample_ext > entry) begin
            combined = sample_ext;
        end
    end

    always_comb begin
        result = combined[DATA_WIDTH-1:0];
`ifdef POOL2D_AVG_EN
        // Arithmetic shift of a two's complement sum is floor division.
        if (mode == POOL_AVG) begin
            result = DATA_WIDTH'(combined >>> SHIFT);
        end
`endif
    end

    // No reset: entries are always loaded by the first sample of a window
    // before they are combined into.
    always_ff @(posedge clk) begin
        if (fire) begin
            acc_mem[wc] <= combined;
        end
    end

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream
// Streaming non-overlapping 2-D pooling (max or average) over a channel-major
// raster stream, using a single row of window accumulators.
//
// Optional feature macro: POOL2D_AVG_EN (enables average mode; otherwise
// 'mode' is ignored and the block always max-pools).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a frame (only sampled in IDLE)
//   mode                : 0 = max, 1 = average (latched at start)
//   in_data/in_valid/in_ready    : input stream handshake
//   out_data/out_valid/out_ready : output stream handshake
//   busy                : frame in progress (RUN or DONE)
//   done                : one-cycle pulse after the last output is accepted
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IN_HEIGHT  = 256,
    parameter int IN_WIDTH   = 256,
    parameter int CHANNELS   = 64,
    parameter int POOL_SIZE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_WIDTH = IN_WIDTH / POOL_SIZE;
    localparam int LOG2P     = $clog2(POOL_SIZE);
    localparam int COL_W     = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int ROW_W     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int CH_W      = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
    localparam int WC_W      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    generate
        if (POOL_SIZE != 2 && POOL_SIZE != 4) begin : g_bad_pool
            $error("pool2d_stream: POOL_SIZE must be 2 or 4");
        end
        if ((IN_WIDTH % POOL_SIZE) != 0 || (IN_HEIGHT % POOL_SIZE) != 0) begin : g_bad_dims
            $error("pool2d_stream: IN_WIDTH and IN_HEIGHT must be multiples of POOL_SIZE");
        end
    endgenerate

    pool_state_e             state_reg, state_next;
    pool_mode_e              mode_reg;
    logic [COL_W-1:0]        col_reg;
    logic [ROW_W-1:0]        row_reg;
    logic [CH_W-1:0]         chan_reg;
    logic                    inputs_done_reg;
    logic                    out_valid_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;

    logic                    in_fire;
    logic                    out_fire;
    logic                    win_first;
    logic                    win_last;
    logic                    col_last;
    logic                    row_last;
    logic                    final_in;
    logic [WC_W-1:0]         wc;
    logic [DATA_WIDTH-1:0]   result;

    // inputs_done_reg blocks any sample after the final one of the frame.
    assign in_ready  = (state_reg == RUN) && !inputs_done_reg && (!out_valid_reg || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    // POOL_SIZE is a power of two, so mod/div are plain bit fields.
    assign win_first = (row_reg[LOG2P-1:0] == '0) && (col_reg[LOG2P-1:0] == '0);
    assign win_last  = (row_reg[LOG2P-1:0] == '1) && (col_reg[LOG2P-1:0] == '1);
    assign col_last  = (col_reg  == COL_W'(IN_WIDTH - 1));
    assign row_last  = (row_reg  == ROW_W'(IN_HEIGHT - 1));
    assign final_in  = col_last && row_last && (chan_reg == CH_W'(CHANNELS - 1));

    generate
        if (OUT_WIDTH > 1) begin : g_wc
            assign wc = col_reg[COL_W-1:LOG2P];
        end else begin : g_wc_single
            assign wc = '0;
        end
    endgenerate

    pool_row_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .POOL_SIZE  (POOL_SIZE),
        .OUT_WIDTH  (OUT_WIDTH),
        .WC_W       (WC_W)
    ) u_row_accum (
        .clk    (clk),
        .fire   (in_fire),
        .first  (win_first),
        .mode   (mode_reg),
        .wc     (wc),
        .sample (in_data),
        .result (result)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (inputs_done_reg && out_fire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            mode_reg        <= POOL_MAX;
            col_reg         <= '0;
            row_reg         <= '0;
            chan_reg        <= '0;
            inputs_done_reg <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && start) begin
                mode_reg        <= mode ? POOL_AVG : POOL_MAX;
                col_reg         <= '0;
                row_reg         <= '0;
                chan_reg        <= '0;
                inputs_done_reg <= 1'b0;
            end

            if (in_fire) begin
                if (col_last) begin
                    col_reg <= '0;
                    if (row_last) begin
                        row_reg  <= '0;
                        chan_reg <= final_in ? '0 : chan_reg + 1'b1;
                    end else begin
                        row_reg <= row_reg + 1'b1;
                    end
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
                if (final_in) begin
                    inputs_done_reg <= 1'b1;
                end
            end

            // A completing window may reload the register in the same cycle
            // the previous result is accepted, so there is no bubble.
            if (in_fire && win_last) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= result;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream
// Two pooling instances share the stimulus: dut_a (4x4x2, P=2) and
// dut_b (8x8x2, P=4). 'sel' picks which one receives start and whose
// outputs are observed; the other stays in IDLE. Expected outputs come from
// a window-by-window reference computed over the whole frame.
module tb_pool2d_stream;

    localparam int DW    = 16;
    localparam int LIMIT = 20000;
`ifdef POOL2D_AVG_EN
    localparam bit AVG_BUILT = 1'b1;
`else
    localparam bit AVG_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          sel = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          start_a, start_b;
    logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [DW-1:0] out_data_a, out_data_b;
    logic          in_ready, out_valid, busy, done;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;
    int din[$];
    int expq[$];

    always #5 clk = ~clk;

    assign start_a   = start && !sel;
    assign start_b   = start && sel;
    assign in_ready  = sel ? in_ready_b  : in_ready_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign out_data  = sel ? out_data_b  : out_data_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign done      = sel ? done_b      : done_a;

    pool2d_stream #(
        .DATA_WIDTH (DW), .IN_HEIGHT (4), .IN_WIDTH (4), .CHANNELS (2), .POOL_SIZE (2)
    ) dut_a (
        .clk (clk), .rst (rst), .start (start_a), .mode (mode),
        .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready_a),
        .out_data (out_data_a), .out_valid (out_valid_a), .out_ready (out_ready),
        .busy (busy_a), .done (done_a)
    );

    pool2d_stream #(
        .DATA_WIDTH (DW), .IN_HEIGHT (8), .IN_WIDTH (8), .CHANNELS (2), .POOL_SIZE (4)
    ) dut_b (
        .clk (clk), .rst (rst), .start (start_b), .mode (mode),
        .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready_b),
        .out_data (out_data_b), .out_valid (out_valid_b), .out_ready (out_ready),
        .busy (busy_b), .done (done_b)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: pat 0 = raster 0..N-1, pat 1 = random signed,
    // pat 2 = raster with the first window of channel 0 set to -1,-2,-1,-2.
    task automatic build_frame(input int h, input int w, input int c, input int p,
                               input int pat, input bit md);
        int v, s, q, n;
        bit first;
        din.delete();
        expq.delete();
        for (int i = 0; i < h * w * c; i++) begin
            if (pat == 1) v = int'($urandom_range(0, 65535)) - 32768;
            else          v = i;
            din.push_back(v);
        end
        if (pat == 2) begin
            din[0] = -1; din[1] = -2; din[w] = -1; din[w + 1] = -2;
        end
        n = p * p;
        for (int ch = 0; ch < c; ch++)
            for (int orow = 0; orow < h / p; orow++)
                for (int ocol = 0; ocol < w / p; ocol++) begin
                    s = 0; q = 0; first = 1'b1;
                    for (int dr = 0; dr < p; dr++)
                        for (int dc = 0; dc < p; dc++) begin
                            v = din[ch * h * w + (orow * p + dr) * w + ocol * p + dc];
                            s += v;
                            if (first || v > q) q = v;
                            first = 1'b0;
                        end
                    if (md && AVG_BUILT) begin
                        q = s / n;
                        if ((s % n) != 0 && s < 0) q = q - 1;
                    end
                    expq.push_back(q);
                end
    endtask

    task automatic run_frame(input bit s, input bit md, input int pat, input bit rnd,
                             input int abort_after);
        int h, w, c, p, n_in, n_out;
        int idx = 0, oi = 0, cyc = 0;
        bit stall_prev = 1'b0;
        logic [DW-1:0] held = '0;
        if (s) begin h = 8; w = 8; c = 2; p = 4; end
        else   begin h = 4; w = 4; c = 2; p = 2; end
        build_frame(h, w, c, p, pat, md);
        n_in  = din.size();
        n_out = expq.size();
        frame_no++;

        // Samples offered while idle must be ignored.
        sel = s; mode = md; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'(din[0]);
        @(negedge clk); #1;
        check("idle_in_ready", in_ready, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_out_valid", out_valid, 1'b0);
        start = 1'b1;
        @(negedge clk);

        while (oi < n_out && !(abort_after > 0 && idx >= abort_after) && cyc < LIMIT) begin
            in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = (idx < n_in) ? 16'(din[idx]) : '0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (cyc == 3);   // must be ignored while running
            #1;
            if (stall_prev) begin
                check("stall_out_valid", out_valid, 1'b1);
                check("stall_out_data", out_data, held);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 1'b0);
            check("no_early_done", done, 1'b0);
            if (in_valid && in_ready) begin
                check("extra_input", idx < n_in, 1'b1);
                idx++;
            end
            if (out_valid && out_ready) begin
                $display("frame %0d out %0d: got %0d expected %0d",
                         frame_no, oi, $signed(out_data), expq[oi]);
                check("out_data", $signed(out_data), expq[oi]);
                oi++;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        check("frame_timeout", cyc < LIMIT, 1'b1);

        if (abort_after == 0) begin
            #1;
            check("done_pulse", done, 1'b1);
            check("done_busy", busy, 1'b1);
            check("inputs_consumed", idx, n_in);
            @(negedge clk); #1;
            check("done_cleared", done, 1'b0);
            check("busy_cleared", busy, 1'b0);
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        run_frame(1'b0, 1'b0, 0, 1'b0, 0);   // max, raster, ready high
        run_frame(1'b0, 1'b1, 0, 1'b0, 0);   // avg, raster
        run_frame(1'b0, 1'b1, 2, 1'b0, 0);   // avg, negative floor window
        run_frame(1'b1, 1'b0, 1, 1'b1, 0);   // P=4, random data and backpressure
        run_frame(1'b1, 1'b1, 1, 1'b1, 0);
        run_frame(1'b1, 1'b0, 1, 1'b1, 0);
        run_frame(1'b0, 1'b1, 1, 1'b1, 0);

        // Abort after 9 inputs with reset, then a clean full frame.
        run_frame(1'b0, 1'b0, 1, 1'b0, 9);
        rst = 1'b1;
        @(negedge clk); #1;
        check_reset_values();
        rst = 1'b0;
        @(negedge clk); #1;
        check("abort_no_done", done, 1'b0);
        run_frame(1'b0, 1'b0, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
